// File: rtl/mem_load_pkg.sv
// Shared types and default widths for the memory load path.
// State encodings cover the LOAD_READBACK_EN verify states even when that macro is off.
package mem_load_pkg;

    localparam int NIB_W       = 4;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_NIB_CNT = 4;
    localparam int IDX_W       = 2;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
        VERIFY_RD,
        VERIFY_CMP,
        ADVANCE,
        FULL
    } state_t;

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector producing a one-cycle pulse.
// Reusable for any debounced step button.
module pulse_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic sync_1;
    logic sync_2;
    logic sync_3;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            sync_3 <= 1'b0;
        end else begin
            sync_1 <= level;
            sync_2 <= sync_1;
            sync_3 <= sync_2;
        end
    end

    assign pulse = sync_2 & ~sync_3;

endmodule

// File: rtl/mem_load_controller.sv
// Assembles hex nibbles entered on switches into words and writes them to RAM at an
// auto-incrementing address. Optional readback verify is enabled with LOAD_READBACK_EN.
module mem_load_controller
    import mem_load_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NIB_CNT = DEF_NIB_CNT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_en,
    input  logic              clr_addr,
    input  logic              enter,
    input  logic [NIB_W-1:0]  nib_in,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [DATA_W-1:0] stage_word,
    output logic [IDX_W-1:0]  nib_idx,
    output logic              full,
    output logic              verr
);

    state_t            state_q, state_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] stage_q, stage_n;
    logic [IDX_W-1:0]  nib_q, nib_n;
    logic              full_q, full_n;
    logic              verr_q, verr_n;
    logic              enter_p;
    logic              mismatch;
    logic              we;

    pulse_sync_edge u_enter_sync (
        .clock (clock),
        .reset (reset),
        .level (enter),
        .pulse (enter_p)
    );

`ifdef LOAD_READBACK_EN
    assign mismatch = (mem_rdata != stage_q);
`else
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
    assign mismatch     = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            stage_q <= '0;
            nib_q   <= '0;
            full_q  <= 1'b0;
            verr_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            addr_q  <= addr_n;
            stage_q <= stage_n;
            nib_q   <= nib_n;
            full_q  <= full_n;
            verr_q  <= verr_n;
        end
    end

    // WRITE always completes; only afterwards do clr_addr and load_en take effect.
    always_comb begin
        state_n = state_q;
        addr_n  = addr_q;
        stage_n = stage_q;
        nib_n   = nib_q;
        full_n  = full_q;
        verr_n  = verr_q;
        we      = 1'b0;

        if (state_q == WRITE) begin
            we = 1'b1;
`ifdef LOAD_READBACK_EN
            state_n = VERIFY_RD;
`else
            state_n = ADVANCE;
`endif
        end else if (clr_addr) begin
            addr_n  = '0;
            stage_n = '0;
            nib_n   = '0;
            full_n  = 1'b0;
            verr_n  = 1'b0;
            state_n = load_en ? COLLECT : IDLE;
        end else if (!load_en) begin
            stage_n = '0;
            nib_n   = '0;
            state_n = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!full_q) state_n = COLLECT;
                end
                COLLECT: begin
                    if (enter_p) begin
                        stage_n = {stage_q[DATA_W-NIB_W-1:0], nib_in};
                        if (nib_q == IDX_W'(NIB_CNT - 1)) begin
                            nib_n   = '0;
                            state_n = WRITE;
                        end else begin
                            nib_n = nib_q + 1'b1;
                        end
                    end
                end
                VERIFY_RD: state_n = VERIFY_CMP;
                VERIFY_CMP: begin
                    if (mismatch) verr_n = 1'b1;
                    state_n = ADVANCE;
                end
                ADVANCE: begin
                    stage_n = '0;
                    if (addr_q == {ADDR_W{1'b1}}) begin
                        full_n  = 1'b1;
                        state_n = FULL;
                    end else begin
                        addr_n  = addr_q + 1'b1;
                        state_n = COLLECT;
                    end
                end
                FULL:    state_n = FULL;
                default: state_n = IDLE;
            endcase
        end
    end

    assign mem_addr   = addr_q;
    assign mem_wdata  = stage_q;
    assign mem_we     = we;
    assign stage_word = stage_q;
    assign nib_idx    = nib_q;
    assign full       = full_q;
    assign verr       = verr_q;

endmodule
